// File: rtl/sram_rd_stream_pkg.sv
// rtl/sram_rd_stream_pkg.sv - shared levels and FSM encoding for the SRAM read sequencer
package sram_rd_stream_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ReadEnable  = 1'b1;
    localparam logic ReadDisable = 1'b0;

    typedef enum logic [1:0] {
        SRS_IDLE  = 2'd0,
        SRS_RUN   = 2'd1,
        SRS_DRAIN = 2'd2,
        SRS_FIN   = 2'd3
    } srs_state_t;

endpackage

// File: rtl/sram_rd_skid.sv
// rtl/sram_rd_skid.sv - two-entry output FIFO holding {last, data} beats
// Ports: clk/rst (shared with parent), push/din write side,
//        pop/dout/valid read side (dout is the head entry), occ = entries held (0..2).
module sram_rd_skid
    import sram_rd_stream_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;

    // When full, push and pop in the same cycle write the slot being vacated,
    // which becomes the new tail, so ordering is preserved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: ;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign valid = (occ != 2'd0);

endmodule

// File: rtl/sram_rd_stream.sv
// rtl/sram_rd_stream.sv - SRAM address-range reader presenting words as a valid/ready stream
// Ports: clk/rst; ce chip enable; start/base_addr/len request (sampled in IDLE);
//        busy/done status; raddr/re/rdata SRAM read port (1-cycle latency);
//        out_valid/out_ready/out_data/out_last output stream.
module sram_rd_stream
    import sram_rd_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  re,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    srs_state_t              state;
    srs_state_t              next_state;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [ADDR_WIDTH:0]     remaining;
    logic                    inflight;
    logic                    inflight_last;
    logic                    issue;
    logic                    pop;
    logic                    buf_valid;
    logic [1:0]              occ;
    logic [DATA_WIDTH:0]     buf_dout;

    assign pop = buf_valid & out_ready;

    // Credit check: occ + inflight - pop < 2, rearranged to avoid a negative term.
    // Guarantees a slot exists for every word arriving a cycle after issue.
    assign issue = (state == SRS_RUN) && (ce == ChipEnable) &&
                   (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

    assign re    = issue ? ReadEnable : ReadDisable;
    assign raddr = cur_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state         <= SRS_IDLE;
            cur_addr      <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= next_state;
            inflight      <= issue;
            inflight_last <= issue && (remaining == CNT_ONE);
            if (state == SRS_IDLE && start && len != '0) begin
                cur_addr  <= base_addr;
                remaining <= len;
            end else if (issue) begin
                cur_addr  <= ADDR_WIDTH'((32'(cur_addr) + 32'd1) % DATA_DEPTH);
                remaining <= remaining - CNT_ONE;
            end
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            SRS_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = (len == '0) ? SRS_FIN : SRS_RUN;
                end
            end
            SRS_RUN: begin
                if (issue && remaining == CNT_ONE) begin
                    next_state = SRS_DRAIN;
                end
            end
            SRS_DRAIN: begin
                if (pop && buf_dout[DATA_WIDTH]) begin
                    next_state = SRS_FIN;
                end
            end
            SRS_FIN: begin
                done       = 1'b1;
                next_state = SRS_IDLE;
            end
            default: next_state = SRS_IDLE;
        endcase
    end

    sram_rd_skid #(
        .W (DATA_WIDTH + 1)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   ({inflight_last, rdata}),
        .pop   (pop),
        .dout  (buf_dout),
        .valid (buf_valid),
        .occ   (occ)
    );

    assign out_valid = buf_valid;
    assign out_data  = buf_dout[DATA_WIDTH-1:0];
    assign out_last  = buf_dout[DATA_WIDTH];

endmodule

// File: tb/tb_sram_rd_stream.sv
// tb/tb_sram_rd_stream.sv - directed self-checking bench for sram_rd_stream
module tb_sram_rd_stream;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DD = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] raddr;
    logic          re;
    logic [DW-1:0] rdata = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    logic [DW-1:0] mem [DD];

    int n_checks = 0;
    int n_fail   = 0;

    int raddr_q[$];
    int beat_q[$];
    int last_q[$];
    int beat_k[$];
    int done_k[$];
    int issued, popped, credit_viol, hold_viol, ce_lo_re, ce_lo_cycles;
    int first_re_k, first_valid_k;
    logic busy_k0;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    logic prev_last;

    sram_rd_stream #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DATA_DEPTH (DD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .raddr     (raddr),
        .re        (re),
        .rdata     (rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

    task automatic clear_logs();
        raddr_q.delete(); beat_q.delete(); last_q.delete(); beat_k.delete(); done_k.delete();
        issued = 0; popped = 0; credit_viol = 0; hold_viol = 0; ce_lo_re = 0; ce_lo_cycles = 0;
        first_re_k = -1; first_valid_k = -1; busy_k0 = 1'b0; prev_stall = 1'b0;
        prev_data = '0; prev_last = 1'b0;
    endtask

    task automatic do_start(input int b, input int l);
        @(posedge clk); #1;
        base_addr = AW'(b); len = (AW+1)'(l); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // k = 0 is the cycle right after the edge that sampled start.
    task automatic run_cycles(input int n, input int rdy_mode, input int ce_lo, input int ce_hi,
                              input int restart_k);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) busy_k0 = busy;
            if (ce == 1'b0) begin
                ce_lo_cycles++;
                if (re) ce_lo_re++;
            end
            if (re) begin
                if (first_re_k < 0) first_re_k = k;
                if (issued - popped - ((out_valid && out_ready) ? 1 : 0) > 1) credit_viol++;
                issued++;
                raddr_q.push_back(int'(raddr));
            end
            if (out_valid && first_valid_k < 0) first_valid_k = k;
            if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
                hold_viol++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && out_ready) begin
                popped++;
                beat_q.push_back(int'(out_data));
                last_q.push_back(int'(out_last));
                beat_k.push_back(k);
            end
            if (done) done_k.push_back(k);
            @(posedge clk); #1;
            if (rdy_mode == 1) begin
                case ((k + 1) % 4)
                    0, 3:    out_ready = 1'b1;
                    default: out_ready = 1'b0;
                endcase
            end else begin
                out_ready = 1'b1;
            end
            ce = (k + 1 >= ce_lo && k + 1 < ce_hi) ? 1'b0 : 1'b1;
            if (k + 1 == restart_k) begin
                start = 1'b1; base_addr = 4'd9; len = 5'd3;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (re !== 1'b0) begin n_fail++; $display("FAIL reset_re got %b exp 0", re); end
        n_checks++; if (raddr !== 4'd0) begin n_fail++; $display("FAIL reset_raddr got %0d exp 0", raddr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b exp 0", out_last); end
    endtask

    task automatic check_sweep(input string tag);
        n_checks++;
        if (beat_q.size() !== 16) begin n_fail++; $display("FAIL %s_count got %0d exp 16", tag, beat_q.size()); end
        for (int i = 0; i < beat_q.size() && i < 16; i++) begin
            n_checks++;
            if (beat_q[i] !== 'hA0 + i || last_q[i] !== ((i == 15) ? 1 : 0) || beat_k[i] !== 2 + i) begin
                n_fail++;
                $display("FAIL %s_beat%0d got data %h last %0d k %0d exp data %h last %0d k %0d",
                         tag, i, beat_q[i], last_q[i], beat_k[i], 'hA0 + i, (i == 15) ? 1 : 0, 2 + i);
            end
        end
        n_checks++;
        if (done_k.size() !== 1 || done_k[0] !== 18) begin
            n_fail++; $display("FAIL %s_done got %0d pulses first k %0d exp 1 pulse at k 18",
                               tag, done_k.size(), (done_k.size() > 0) ? done_k[0] : -1);
        end
        n_checks++; if (first_re_k !== 0) begin n_fail++; $display("FAIL %s_first_re got k %0d exp 0", tag, first_re_k); end
        n_checks++; if (first_valid_k !== 2) begin n_fail++; $display("FAIL %s_first_valid got k %0d exp 2", tag, first_valid_k); end
        n_checks++; if (busy_k0 !== 1'b1) begin n_fail++; $display("FAIL %s_busy got %b exp 1", tag, busy_k0); end
    endtask

    task automatic test_full_sweep();
        clear_logs();
        do_start(0, 16);
        run_cycles(24, 0, -1, -1, -1);
        check_sweep("sweep");
    endtask

    task automatic test_wrap();
        clear_logs();
        do_start(14, 4);
        run_cycles(12, 0, -1, -1, -1);
        n_checks++;
        if (raddr_q.size() !== 4 || beat_q.size() !== 4) begin
            n_fail++; $display("FAIL wrap_count got raddrs %0d beats %0d exp 4 4", raddr_q.size(), beat_q.size());
        end
        for (int i = 0; i < 4 && i < raddr_q.size() && i < beat_q.size(); i++) begin
            n_checks++;
            if (raddr_q[i] !== (14 + i) % 16 || beat_q[i] !== 'hA0 + (14 + i) % 16 || last_q[i] !== ((i == 3) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL wrap_beat%0d got addr %0d data %h last %0d exp addr %0d data %h last %0d",
                         i, raddr_q[i], beat_q[i], last_q[i], (14 + i) % 16, 'hA0 + (14 + i) % 16, (i == 3) ? 1 : 0);
            end
        end
        n_checks++; if (done_k.size() !== 1) begin n_fail++; $display("FAIL wrap_done got %0d pulses exp 1", done_k.size()); end
    endtask

    task automatic test_backpressure();
        clear_logs();
        out_ready = 1'b1;
        do_start(2, 8);
        run_cycles(60, 1, -1, -1, -1);
        n_checks++; if (beat_q.size() !== 8) begin n_fail++; $display("FAIL bp_count got %0d exp 8", beat_q.size()); end
        for (int i = 0; i < beat_q.size() && i < 8; i++) begin
            n_checks++;
            if (beat_q[i] !== 'hA2 + i || last_q[i] !== ((i == 7) ? 1 : 0)) begin
                n_fail++; $display("FAIL bp_beat%0d got data %h last %0d exp data %h last %0d",
                                   i, beat_q[i], last_q[i], 'hA2 + i, (i == 7) ? 1 : 0);
            end
        end
        n_checks++; if (credit_viol !== 0) begin n_fail++; $display("FAIL bp_credit got %0d violations exp 0", credit_viol); end
        n_checks++; if (hold_viol !== 0) begin n_fail++; $display("FAIL bp_hold got %0d violations exp 0", hold_viol); end
        n_checks++; if (done_k.size() !== 1) begin n_fail++; $display("FAIL bp_done got %0d pulses exp 1", done_k.size()); end
        out_ready = 1'b1;
    endtask

    task automatic test_ce_stall();
        clear_logs();
        do_start(0, 10);
        run_cycles(30, 0, 3, 6, 4);
        n_checks++; if (ce_lo_cycles !== 3) begin n_fail++; $display("FAIL ce_window got %0d cycles exp 3", ce_lo_cycles); end
        n_checks++; if (ce_lo_re !== 0) begin n_fail++; $display("FAIL ce_re got %0d reads while ce low exp 0", ce_lo_re); end
        n_checks++;
        if (raddr_q.size() !== 10 || beat_q.size() !== 10) begin
            n_fail++; $display("FAIL ce_count got raddrs %0d beats %0d exp 10 10", raddr_q.size(), beat_q.size());
        end
        for (int i = 0; i < 10 && i < raddr_q.size() && i < beat_q.size(); i++) begin
            n_checks++;
            if (raddr_q[i] !== i || beat_q[i] !== 'hA0 + i || last_q[i] !== ((i == 9) ? 1 : 0)) begin
                n_fail++; $display("FAIL ce_beat%0d got addr %0d data %h last %0d exp addr %0d data %h last %0d",
                                   i, raddr_q[i], beat_q[i], last_q[i], i, 'hA0 + i, (i == 9) ? 1 : 0);
            end
        end
        n_checks++; if (done_k.size() !== 1) begin n_fail++; $display("FAIL ce_done got %0d pulses exp 1", done_k.size()); end
    endtask

    task automatic test_zero_len();
        clear_logs();
        do_start(3, 0);
        run_cycles(6, 0, -1, -1, -1);
        n_checks++; if (raddr_q.size() !== 0) begin n_fail++; $display("FAIL zero_re got %0d reads exp 0", raddr_q.size()); end
        n_checks++; if (first_valid_k !== -1) begin n_fail++; $display("FAIL zero_valid got k %0d exp none", first_valid_k); end
        n_checks++;
        if (done_k.size() !== 1 || done_k[0] !== 0) begin
            n_fail++; $display("FAIL zero_done got %0d pulses first k %0d exp 1 pulse at k 0",
                               done_k.size(), (done_k.size() > 0) ? done_k[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        do_start(0, 16);
        run_cycles(4, 0, -1, -1, -1);
        n_checks++; if (beat_q.size() !== 2) begin n_fail++; $display("FAIL rstmid_pre got %0d beats exp 2", beat_q.size()); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({re, raddr, busy, done, out_valid, out_data, out_last} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs got re %b raddr %0d busy %b done %b valid %b data %h last %b exp all 0",
                               re, raddr, busy, done, out_valid, out_data, out_last);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got %b exp 0", done); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got done %b busy %b exp 0 0", done, busy); end
        clear_logs();
        do_start(0, 16);
        run_cycles(24, 0, -1, -1, -1);
        check_sweep("rstmid_sweep");
    endtask

    initial begin
        for (int i = 0; i < DD; i++) mem[i] = 8'hA0 + 8'(i);
        clear_logs();
        test_reset();
        test_full_sweep();
        test_wrap();
        test_backpressure();
        test_ce_stall();
        test_zero_len();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
